// File: rtl/key_pkg.sv
// Shared definitions for the push-button conditioner: key indices, debounce FSM
// encoding and default timing constants.
package key_pkg;

   localparam int NUM_KEYS  = 4;
   localparam int KEY_START = 0;
   localparam int KEY_UP    = 1;
   localparam int KEY_LEFT  = 2;
   localparam int KEY_RIGHT = 3;

   localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
   localparam int SYNC_STAGES_DEFAULT     = 2;

   // Bit 1 of the encoding is the debounced key level.
   typedef enum logic [1:0] {
      ST_RELEASED     = 2'b00,
      ST_PRESS_PEND   = 2'b01,
      ST_PRESSED      = 2'b11,
      ST_RELEASE_PEND = 2'b10
   } key_state_e;

   function automatic logic state_is_down(input key_state_e st);
      return (st == ST_PRESSED) || (st == ST_RELEASE_PEND);
   endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: synchroniser, four-state debounce FSM with saturating counter, and
// registered level/edge outputs. Release pulse built only with KEY_RELEASE_PULSE_EN.
module key_debounce
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic key_n_i,
   output logic btn_o,
   output logic press_o,
   output logic release_o
);

   localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   key_s;
   key_state_e             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   btn_q;
   logic                   press_q;
   logic                   press_d;
   logic                   cnt_done;

   assign key_s    = sync_q[SYNC_STAGES-1];
   assign cnt_done = (cnt_q == CNT_MAX);
   assign press_d  = (state_q == ST_PRESS_PEND) && key_s && cnt_done;

   // The counter only runs in the two pending states and is cleared on every
   // exit, so it stays within 0..DEBOUNCE_CYCLES-1 and cannot wrap.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_RELEASED: begin
            if (key_s) begin
               state_d = ST_PRESS_PEND;
               cnt_d   = '0;
            end
         end
         ST_PRESS_PEND: begin
            if (!key_s) begin
               state_d = ST_RELEASED;
               cnt_d   = '0;
            end else if (cnt_done) begin
               state_d = ST_PRESSED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_PRESSED: begin
            if (!key_s) begin
               state_d = ST_RELEASE_PEND;
               cnt_d   = '0;
            end
         end
         ST_RELEASE_PEND: begin
            if (key_s) begin
               state_d = ST_PRESSED;
               cnt_d   = '0;
            end else if (cnt_done) begin
               state_d = ST_RELEASED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_RELEASED;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q  <= '0;
         state_q <= ST_RELEASED;
         cnt_q   <= '0;
         btn_q   <= 1'b0;
         press_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], ~key_n_i};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         btn_q   <= state_is_down(state_d);
         press_q <= press_d;
      end
   end

   assign btn_o   = btn_q;
   assign press_o = press_q;

`ifdef KEY_RELEASE_PULSE_EN
   logic release_q;
   logic release_d;

   assign release_d = (state_q == ST_RELEASE_PEND) && !key_s && cnt_done;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         release_q <= 1'b0;
      end else begin
         release_q <= release_d;
      end
   end

   assign release_o = release_q;
`else
   assign release_o = 1'b0;
`endif

endmodule

// File: rtl/key_conditioner.sv
// Four-key push-button conditioner: one independent debouncer per key.
// Optional feature macro: KEY_RELEASE_PULSE_EN (enables btn_release pulses).
module key_conditioner
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int SYNC_STAGES     = SYNC_STAGES_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] key_n,
   output logic [NUM_KEYS-1:0] btn,
   output logic [NUM_KEYS-1:0] btn_press,
   output logic [NUM_KEYS-1:0] btn_release
);

   // Bit order follows KEY_START, KEY_UP, KEY_LEFT, KEY_RIGHT.
   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .SYNC_STAGES     (SYNC_STAGES)
      ) u_key_debounce (
         .clk_i     (clk),
         .rst_ni    (reset),
         .key_n_i   (key_n[i]),
         .btn_o     (btn[i]),
         .press_o   (btn_press[i]),
         .release_o (btn_release[i])
      );
   end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2; expected
// outputs are derived from the key plans and checked cycle by cycle.
module tb_key_conditioner;
   import key_pkg::*;

   localparam int DC  = 4;
   localparam int SS  = 2;
   localparam int LAT = SS + DC;
   localparam int RUN = 60;

   typedef struct {
      int g_start;
      int g_len;
      int p_start;
      int p_len;
   } key_plan_t;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic [NUM_KEYS-1:0] key_n = '1;
   logic [NUM_KEYS-1:0] btn;
   logic [NUM_KEYS-1:0] btn_press;
   logic [NUM_KEYS-1:0] btn_release;

   int          checks = 0;
   int          errors = 0;
   logic [11:0] exp_q[$];
   key_plan_t   plan[NUM_KEYS];
   int          rst_lo;
   int          rst_hi;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   key_conditioner #(
      .DEBOUNCE_CYCLES (DC),
      .SYNC_STAGES     (SS)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .key_n       (key_n),
      .btn         (btn),
      .btn_press   (btn_press),
      .btn_release (btn_release)
   );

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   function automatic logic in_win(input int n, input int s, input int l);
      return (l > 0) && (n >= s) && (n < s + l);
   endfunction

   // Expected outputs after clock edge n: a held key shows up LAT edges after
   // its first low sample (or after reset release if reset overlapped it).
   function automatic logic [11:0] expect_at(input int n);
      logic [3:0] b;
      logic [3:0] p;
      logic [3:0] r;
      b = '0;
      p = '0;
      r = '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
         int ps;
         int pe;
         ps = plan[k].p_start;
         pe = plan[k].p_start + plan[k].p_len;
         if (plan[k].p_len > 0) begin
            if (rst_hi >= 0 && ps <= rst_hi) ps = rst_hi + 1;
            b[k] = (n >= ps + LAT) && (n < pe + LAT);
            p[k] = (n == ps + LAT);
`ifdef KEY_RELEASE_PULSE_EN
            r[k] = (n == pe + LAT);
`endif
         end
      end
      return {b, p, r};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic clear_plan();
      for (int k = 0; k < NUM_KEYS; k++) begin
         plan[k].g_start = 0;
         plan[k].g_len   = 0;
         plan[k].p_start = 0;
         plan[k].p_len   = 0;
      end
      rst_lo = -1;
      rst_hi = -1;
   endtask

   task automatic set_key(input int k, input int gs, input int gl, input int ps, input int pl);
      plan[k].g_start = gs;
      plan[k].g_len   = gl;
      plan[k].p_start = ps;
      plan[k].p_len   = pl;
   endtask

   task automatic drive(input int n);
      for (int k = 0; k < NUM_KEYS; k++) begin
         key_n[k] = !(in_win(n, plan[k].g_start, plan[k].g_len) ||
                      in_win(n, plan[k].p_start, plan[k].p_len));
      end
      reset = !(rst_lo >= 0 && n >= rst_lo && n <= rst_hi);
   endtask

   task automatic run_scenario(input int id);
      logic [11:0] e;
      reset = 1'b0;
      key_n = '1;
      exp_q.delete();
      repeat (3) @(negedge clk);
      check_eq($sformatf("s%0d reset btn", id), btn, 4'h0);
      check_eq($sformatf("s%0d reset press", id), btn_press, 4'h0);
      check_eq($sformatf("s%0d reset release", id), btn_release, 4'h0);
      for (int n = 1; n <= RUN; n++) begin
         drive(n);
         exp_q.push_back(expect_at(n));
         @(posedge clk);
         @(negedge clk);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL s%0d c%0d scoreboard: got empty queue expected entry", id, n);
         end else begin
            e = exp_q.pop_front();
            check_eq($sformatf("s%0d c%0d btn", id, n), btn, e[11:8]);
            check_eq($sformatf("s%0d c%0d press", id, n), btn_press, e[7:4]);
            check_eq($sformatf("s%0d c%0d release", id, n), btn_release, e[3:0]);
         end
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      clear_plan();

      // Held START key.
      clear_plan();
      set_key(KEY_START, 0, 0, 10, 1000);
      run_scenario(1);

      // 3-cycle glitch on LEFT, then a real press one cycle later.
      clear_plan();
      set_key(KEY_LEFT, 10, 3, 14, 1000);
      run_scenario(2);

      // Press and release of UP.
      clear_plan();
      set_key(KEY_UP, 0, 0, 10, 20);
      run_scenario(3);

      // RIGHT held across a reset pulse while still in the synchroniser.
      clear_plan();
      set_key(KEY_RIGHT, 0, 0, 10, 1000);
      rst_lo = 12;
      rst_hi = 13;
      run_scenario(4);

      // Reset in the middle of a pending press.
      clear_plan();
      set_key(KEY_START, 0, 0, 10, 1000);
      rst_lo = 14;
      rst_hi = 15;
      run_scenario(5);

      // All four keys together.
      clear_plan();
      for (int k = 0; k < NUM_KEYS; k++) set_key(k, 0, 0, 10, 16);
      run_scenario(6);

      // Random independent presses followed by short glitches.
      for (int s = 7; s <= 12; s++) begin
         clear_plan();
         for (int k = 0; k < NUM_KEYS; k++) begin
            int ps;
            int pl;
            ps = int'($urandom_range(5, 20));
            pl = int'($urandom_range(8, 20));
            set_key(k, ps + pl + int'($urandom_range(8, 10)), int'($urandom_range(1, DC - 1)), ps, pl);
         end
         run_scenario(s);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of consecutive clk cycles the synchronised input must differ from the debounced state before that state changes. Legal range is 2..2^24.
REQ-002 Parameter SYNC_STAGES, default 2, is the synchroniser depth. Legal range is 2..3.
REQ-003 clk  input  1  system clock (PLL c0); every register is on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; deassertion is synchronous to clk.
REQ-005 key_n  input  4  raw push-buttons, active-low, asynchronous: [0]=START, [1]=UP, [2]=LEFT, [3]=RIGHT.
REQ-006 btn  output  4  debounced key levels, active-high, same bit order as key_n.
REQ-007 btn_press  output  4  one-cycle pulse on each debounced 0->1 transition of btn.
REQ-008 btn_release  output  4  one-cycle pulse on each debounced 1->0 transition of btn.

Function
REQ-009 Each key_n bit shall be inverted and passed through a SYNC_STAGES-deep flip-flop chain; later logic sees only the final stage (s).
REQ-010 Each key shall run an independent FSM: RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND.
REQ-011 RELEASED: s=1 -> PRESS_PEND, counter=0. s=0 -> stay.
REQ-012 PRESS_PEND: s=0 -> RELEASED, counter=0. s=1 with counter=DEBOUNCE_CYCLES-1 -> PRESSED. Otherwise counter+1.
REQ-013 PRESSED and RELEASE_PEND shall mirror REQ-011/012 with s inverted.
REQ-014 btn[i] shall be 1 in PRESSED and RELEASE_PEND, and 0 otherwise.
REQ-015 Latency: a clean raw edge shall reach btn exactly SYNC_STAGES+DEBOUNCE_CYCLES cycles later.
REQ-016 btn_press[i] shall be high for exactly the first cycle btn[i] is 1. btn_release[i] shall be high for exactly the first cycle btn[i] is 0 after being 1.
REQ-017 A glitch shorter than DEBOUNCE_CYCLES cycles shall produce no change on any output. The counter shall restart from 0 on the next qualifying edge.
REQ-018 Keys shall be fully independent. Simultaneous transitions on several keys shall produce simultaneous, independent pulses.
REQ-019 Each counter shall be $clog2(DEBOUNCE_CYCLES) bits, shall never exceed DEBOUNCE_CYCLES-1, and shall never wrap.
REQ-020 All outputs shall be registered, with no combinational path from key_n.

Reset
REQ-021 While reset=0, all FSMs shall be RELEASED, all counters 0, all sync flops 0, and btn, btn_press and btn_release all 0.
REQ-022 Reset asserted mid-debounce shall abandon the pending transition immediately, with no pulse.
REQ-023 A key already held when reset deasserts shall be reported as a normal press after the full REQ-015 latency, including its btn_press pulse.

Configuration
REQ-024 Macro KEY_RELEASE_PULSE_EN controls the btn_release output.
- Defined: btn_release behaves per REQ-008 and REQ-016.
- Undefined: btn_release is tied to 4'b0000 and its edge logic is not built. btn and btn_press are unchanged.

Structure
REQ-025 Shared package key_pkg shall hold:
- key index constants KEY_START=0, KEY_UP=1, KEY_LEFT=2, KEY_RIGHT=3 and NUM_KEYS=4;
- the 2-bit debounce state enum;
- the default DEBOUNCE_CYCLES constant.
REQ-026 Sub-module key_debounce shall implement one key (synchroniser, FSM, counter, pulse logic) and shall be instantiated NUM_KEYS times by generate.

Verification (bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-027 Hold key_n[0]=0 from cycle 10 -> btn[0]=1 and btn_press[0]=1 at cycle 16 only; btn_press[0]=0 at cycle 17.
REQ-028 3-cycle low glitch on key_n[2] -> btn, btn_press and btn_release stay 0 throughout.
REQ-029 Press and release key_n[1] (low cycles 10-29) with KEY_RELEASE_PULSE_EN defined -> btn_release[1]=1 at cycle 36 only. Same stimulus with the macro undefined -> btn_release stays 0.
REQ-030 Raw key_n[3]=0 at cycle 10, reset=0 at cycles 12-13 -> all outputs 0 during reset; btn[3] rises at cycle 20 with a single press pulse.
REQ-031 All four keys pressed in the same cycle -> btn=4'b1111 and btn_press=4'b1111 in the same single cycle.
